// File: rtl/drac_pkg.sv
// drac_pkg: shared data-cache definitions for the Lagarto core side and for
// the L1D request responder.
//   - DCACHE_INDEX_WIDTH / DCACHE_TAG_WIDTH: request address split {tag, index}
//   - L1D_SIZE_B/H/W/D: access size encodings on the *_mem_req_size ports
//   - l1d_resp_state_t: responder load FSM states
//   - l1d_misaligned(): natural-alignment check on addr[2:0] for a given size
package drac_pkg;

   localparam int DCACHE_INDEX_WIDTH = 12;
   localparam int DCACHE_TAG_WIDTH   = 28;
   localparam int DCACHE_ADDR_WIDTH  = DCACHE_TAG_WIDTH + DCACHE_INDEX_WIDTH;

   localparam logic [1:0] L1D_SIZE_B = 2'd0;
   localparam logic [1:0] L1D_SIZE_H = 2'd1;
   localparam logic [1:0] L1D_SIZE_W = 2'd2;
   localparam logic [1:0] L1D_SIZE_D = 2'd3;

   typedef enum logic [1:0] {
      L1D_RESP_IDLE = 2'd0,
      L1D_RESP_TAG  = 2'd1,
      L1D_RESP_PEND = 2'd2,
      L1D_RESP_RESP = 2'd3
   } l1d_resp_state_t;

   // An access is misaligned when the low address bits are not a multiple of
   // the access size in bytes.
   function automatic logic l1d_misaligned(input logic [2:0] addr_lo,
                                           input logic [1:0] size);
      logic mis;
      case (size)
         L1D_SIZE_H: mis = addr_lo[0];
         L1D_SIZE_W: mis = |addr_lo[1:0];
         L1D_SIZE_D: mis = |addr_lo;
         default:    mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lagarto_l1d_req_responder_scratchpad.sv
// l1d_resp_scratchpad: MEM_WORDS x 64-bit backing store for the L1D responder.
// Ports:
//   clk_i, rstn_i       clock, synchronous active-low reset (read register only)
//   we_i, wbe_i         write strobe and byte enables
//   waddr_i, wdata_i    write word address and data
//   re_i, raddr_i       read strobe and word address
//   rdata_o             registered read data, updated only when re_i is high
// A write to the word being read in the same cycle is merged into the read
// data byte-wise (write-first). The array itself is never reset.
module l1d_resp_scratchpad #(
   parameter int MEM_WORDS = 1024,
   parameter int AW        = $clog2(MEM_WORDS)
) (
   input  logic          clk_i,
   input  logic          rstn_i,
   input  logic          we_i,
   input  logic [7:0]    wbe_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [63:0]   wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [63:0]   rdata_o
);

   logic [63:0] mem_q [MEM_WORDS];
   logic [63:0] rd_word;
   logic [63:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 8; b++) begin
            if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem_q[raddr_i];
      if (we_i && (waddr_i == raddr_i)) begin
         for (int b = 0; b < 8; b++) begin
            if (wbe_i[b]) rd_word[8*b +: 8] = wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= rd_word;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/lagarto_l1d_req_responder.sv
// lagarto_l1d_req_responder: responder end of the split load/store L1D request
// ports, backed by a local scratchpad.
// Ports:
//   clk_i, rstn_i              clock, synchronous active-low reset
//   ld_mem_req_*               two-phase load port (index phase, then tag/kill)
//   st_mem_req_*               single-phase store port
//   ld_gnt_o / st_gnt_o        request accepted this cycle (combinational)
//   dmem_resp_data_o/valid_o   registered load response, aligned doubleword
//   dmem_resp_nack_o           load refused because a load is outstanding
//   dmem_xcpt_ma_ld/st_o       misaligned access (only with the macro below)
//   busy_o                     load FSM not idle
// Build option: LAGARTO_L1D_MISALIGN_CHK_EN enables natural-alignment checks;
// without it the exception outputs are 0 and addr[2:0] is ignored.
//
// Load FSM
//   state | meaning
//   IDLE  | no load outstanding, index phase may be granted
//   TAG   | index accepted, waiting for tag phase or kill
//   PEND  | tag accepted, latency counter running down
//   RESP  | response valid on the outputs this cycle
module lagarto_l1d_req_responder
   import drac_pkg::*;
#(
   parameter int MEM_WORDS = 1024,
   parameter int RESP_LAT  = 1
) (
   input  logic                          clk_i,
   input  logic                          rstn_i,
   input  logic [DCACHE_INDEX_WIDTH-1:0] ld_mem_req_addr_index_i,
   input  logic [DCACHE_TAG_WIDTH-1:0]   ld_mem_req_addr_tag_i,
   input  logic                          ld_mem_req_valid_i,
   input  logic                          ld_mem_req_tag_valid_i,
   input  logic                          ld_mem_req_kill_i,
   input  logic                          ld_mem_req_we_i,
   input  logic [7:0]                    ld_mem_req_be_i,
   input  logic [1:0]                    ld_mem_req_size_i,
   input  logic [63:0]                   ld_mem_req_wdata_i,
   input  logic [DCACHE_INDEX_WIDTH-1:0] st_mem_req_addr_index_i,
   input  logic [DCACHE_TAG_WIDTH-1:0]   st_mem_req_addr_tag_i,
   input  logic                          st_mem_req_valid_i,
   input  logic                          st_mem_req_tag_valid_i,
   input  logic                          st_mem_req_kill_i,
   input  logic                          st_mem_req_we_i,
   input  logic [7:0]                    st_mem_req_be_i,
   input  logic [1:0]                    st_mem_req_size_i,
   input  logic [63:0]                   st_mem_req_wdata_i,
   output logic                          ld_gnt_o,
   output logic                          st_gnt_o,
   output logic [63:0]                   dmem_resp_data_o,
   output logic                          dmem_resp_valid_o,
   output logic                          dmem_resp_nack_o,
   output logic                          dmem_xcpt_ma_ld_o,
   output logic                          dmem_xcpt_ma_st_o,
   output logic                          busy_o
);

   localparam int WA_W = $clog2(MEM_WORDS);

   l1d_resp_state_t               state_q, state_d;
   logic [1:0]                    cnt_q, cnt_d;
   logic [DCACHE_INDEX_WIDTH-1:0] index_q;
   logic [DCACHE_TAG_WIDTH-1:0]   tag_q;
   logic [1:0]                    size_q;
   logic                          resp_valid_q;
   logic                          rd_en;
   logic                          ld_req, st_req;
   logic                          ld_mis, st_mis;
   logic                          tag_accept;
   logic [DCACHE_ADDR_WIDTH-1:0]  ld_addr, st_addr;

   // Outputs are held at 0 while reset is asserted, even though the request
   // qualifiers are combinational.
   assign ld_req = rstn_i & ld_mem_req_valid_i & ~ld_mem_req_kill_i &
                   (state_q == L1D_RESP_IDLE);
   assign st_req = rstn_i & st_mem_req_valid_i & st_mem_req_tag_valid_i &
                   st_mem_req_we_i & ~st_mem_req_kill_i;

`ifdef LAGARTO_L1D_MISALIGN_CHK_EN
   assign ld_mis            = l1d_misaligned(ld_mem_req_addr_index_i[2:0], ld_mem_req_size_i);
   assign st_mis            = l1d_misaligned(st_mem_req_addr_index_i[2:0], st_mem_req_size_i);
   assign dmem_xcpt_ma_ld_o = ld_req & ld_mis;
   assign dmem_xcpt_ma_st_o = st_req & st_mis;
`else
   assign ld_mis            = 1'b0;
   assign st_mis            = 1'b0;
   assign dmem_xcpt_ma_ld_o = 1'b0;
   assign dmem_xcpt_ma_st_o = 1'b0;
`endif

   assign ld_gnt_o         = ld_req & ~ld_mis;
   assign st_gnt_o         = st_req & ~st_mis;
   assign dmem_resp_nack_o = rstn_i & ld_mem_req_valid_i & (state_q != L1D_RESP_IDLE);
   assign busy_o           = (state_q != L1D_RESP_IDLE);

   // In TAG the tag is still on the input port; afterwards it is latched.
   assign ld_addr = {(state_q == L1D_RESP_TAG) ? ld_mem_req_addr_tag_i : tag_q, index_q};
   assign st_addr = {st_mem_req_addr_tag_i, st_mem_req_addr_index_i};

   assign tag_accept = (state_q == L1D_RESP_TAG) & ~ld_mem_req_kill_i &
                       ld_mem_req_tag_valid_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_en   = 1'b0;
      case (state_q)
         L1D_RESP_IDLE: begin
            if (ld_gnt_o) state_d = L1D_RESP_TAG;
         end
         L1D_RESP_TAG: begin
            if (ld_mem_req_kill_i) begin
               state_d = L1D_RESP_IDLE;
            end else if (ld_mem_req_tag_valid_i) begin
               if (RESP_LAT == 1) begin
                  state_d = L1D_RESP_RESP;
                  rd_en   = 1'b1;
               end else begin
                  state_d = L1D_RESP_PEND;
                  cnt_d   = 2'(RESP_LAT - 1);
               end
            end
         end
         L1D_RESP_PEND: begin
            if (ld_mem_req_kill_i) begin
               state_d = L1D_RESP_IDLE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q - 2'd1;
               // Terminal count: the read happens on the edge the counter hits 0.
               if (cnt_q == 2'd1) begin
                  state_d = L1D_RESP_RESP;
                  rd_en   = 1'b1;
               end
            end
         end
         L1D_RESP_RESP: begin
            state_d = L1D_RESP_IDLE;
         end
         default: state_d = L1D_RESP_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q      <= L1D_RESP_IDLE;
         cnt_q        <= 2'd0;
         index_q      <= '0;
         tag_q        <= '0;
         size_q       <= 2'd0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         resp_valid_q <= rd_en;
         if (ld_gnt_o) begin
            index_q <= ld_mem_req_addr_index_i;
            size_q  <= ld_mem_req_size_i;
         end
         if (tag_accept) tag_q <= ld_mem_req_addr_tag_i;
      end
   end

   assign dmem_resp_valid_o = resp_valid_q;

   l1d_resp_scratchpad #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (WA_W)
   ) u_scratchpad (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .we_i    (st_gnt_o),
      .wbe_i   (st_mem_req_be_i),
      .waddr_i (st_addr[3 +: WA_W]),
      .wdata_i (st_mem_req_wdata_i),
      .re_i    (rd_en),
      .raddr_i (ld_addr[3 +: WA_W]),
      .rdata_o (dmem_resp_data_o)
   );

   // Load-port write fields, the latched size and address bits outside the
   // word index carry no function here.
   logic unused_ok;
   assign unused_ok = ^{ld_mem_req_we_i, ld_mem_req_be_i, ld_mem_req_wdata_i,
                        ld_mem_req_size_i, st_mem_req_size_i, size_q,
                        ld_addr, st_addr};

endmodule

// File: tb/tb_lagarto_l1d_req_responder.sv
module tb_lagarto_l1d_req_responder;
   import drac_pkg::*;

   localparam int MEM_WORDS = 1024;
   localparam int LAT       = 3;

   logic                          clk, rstn;
   logic [DCACHE_INDEX_WIDTH-1:0] ld_index, st_index;
   logic [DCACHE_TAG_WIDTH-1:0]   ld_tag, st_tag;
   logic                          ld_valid, ld_tag_valid, ld_kill, ld_we;
   logic                          st_valid, st_tag_valid, st_kill, st_we;
   logic [7:0]                    ld_be, st_be;
   logic [1:0]                    ld_size, st_size;
   logic [63:0]                   ld_wdata, st_wdata;
   logic                          ld_gnt, st_gnt, resp_valid, nack, xcpt_ld, xcpt_st, busy;
   logic [63:0]                   resp_data;

   lagarto_l1d_req_responder #(.MEM_WORDS(MEM_WORDS), .RESP_LAT(LAT)) dut (
      .clk_i                   (clk),
      .rstn_i                  (rstn),
      .ld_mem_req_addr_index_i (ld_index),
      .ld_mem_req_addr_tag_i   (ld_tag),
      .ld_mem_req_valid_i      (ld_valid),
      .ld_mem_req_tag_valid_i  (ld_tag_valid),
      .ld_mem_req_kill_i       (ld_kill),
      .ld_mem_req_we_i         (ld_we),
      .ld_mem_req_be_i         (ld_be),
      .ld_mem_req_size_i       (ld_size),
      .ld_mem_req_wdata_i      (ld_wdata),
      .st_mem_req_addr_index_i (st_index),
      .st_mem_req_addr_tag_i   (st_tag),
      .st_mem_req_valid_i      (st_valid),
      .st_mem_req_tag_valid_i  (st_tag_valid),
      .st_mem_req_kill_i       (st_kill),
      .st_mem_req_we_i         (st_we),
      .st_mem_req_be_i         (st_be),
      .st_mem_req_size_i       (st_size),
      .st_mem_req_wdata_i      (st_wdata),
      .ld_gnt_o                (ld_gnt),
      .st_gnt_o                (st_gnt),
      .dmem_resp_data_o        (resp_data),
      .dmem_resp_valid_o       (resp_valid),
      .dmem_resp_nack_o        (nack),
      .dmem_xcpt_ma_ld_o       (xcpt_ld),
      .dmem_xcpt_ma_st_o       (xcpt_st),
      .busy_o                  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Start a new cycle: inputs change on the falling edge, outputs are
   // sampled 1ns later, well away from the rising edge.
   task automatic begin_cycle();
      @(negedge clk);
      ld_valid = 0; ld_tag_valid = 0; ld_kill = 0; ld_we = 0; ld_be = 0; ld_wdata = 0;
      st_valid = 0; st_tag_valid = 0; st_kill = 0; st_we = 0; st_be = 0;
   endtask

   task automatic set_ld_req(input logic [39:0] a, input logic [1:0] sz);
      ld_valid = 1; ld_index = a[11:0]; ld_tag = a[39:12]; ld_size = sz;
   endtask

   task automatic set_ld_tag(input logic [39:0] a);
      ld_tag_valid = 1; ld_tag = a[39:12];
   endtask

   task automatic set_st(input logic [39:0] a, input logic [7:0] be, input logic [63:0] d,
                         input logic [1:0] sz);
      st_valid = 1; st_tag_valid = 1; st_we = 1;
      st_index = a[11:0]; st_tag = a[39:12]; st_be = be; st_wdata = d; st_size = sz;
   endtask

   task automatic do_store(input logic [39:0] a, input logic [7:0] be, input logic [63:0] d);
      begin_cycle();
      set_st(a, be, d, L1D_SIZE_D);
      #1;
      chk("st_gnt", st_gnt, 1);
   endtask

   // Full load: grant, tag, then wait for the response with a bounded budget.
   // Optionally a store at tag-cycle offset st_off and a second load request
   // (which must be nacked) at offset nack_off. lat = -1 if no response.
   task automatic do_load(input logic [39:0] a, input logic [1:0] sz,
                          input int st_off, input logic [39:0] sa, input logic [7:0] sbe,
                          input logic [63:0] sd, input int nack_off,
                          output logic [63:0] data, output int lat);
      lat  = -1;
      data = '0;
      begin_cycle();
      set_ld_req(a, sz);
      #1;
      chk("ld_gnt", ld_gnt, 1);
      for (int i = 0; i <= LAT + 4; i++) begin
         begin_cycle();
         if (i == 0) set_ld_tag(a);
         if (i == st_off) set_st(sa, sbe, sd, L1D_SIZE_D);
         if (i == nack_off) set_ld_req(40'h0000_0008, L1D_SIZE_D);
         #1;
         if (i == st_off) chk("st_gnt_during_load", st_gnt, 1);
         if (i == nack_off) begin
            chk("nack_busy", nack, 1);
            chk("gnt_while_busy", ld_gnt, 0);
         end
         if (resp_valid) begin
            lat  = i;
            data = resp_data;
            break;
         end
      end
   endtask

   task automatic expect_no_resp(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         begin_cycle();
         #1;
         if (resp_valid) seen++;
      end
      chk(name, 64'(seen), 0);
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] be);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   typedef struct {
      logic [39:0] st_addr;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [39:0] ld_addr;
      logic [63:0] exp;
   } vec_t;

   vec_t        vecs[7];
   logic [63:0] ref_mem[16];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d;
      int          lat;

      // Hand-computed byte-merge results on one word, plus an aliased address
      // one scratchpad size (0x2000 bytes) above its target.
      vecs[0] = '{40'h100,  8'hFF, 64'h0123456789ABCDEF, 40'h100, 64'h0123456789ABCDEF};
      vecs[1] = '{40'h100,  8'h01, 64'hFFFFFFFFFFFFFF55, 40'h100, 64'h0123456789ABCD55};
      vecs[2] = '{40'h100,  8'h80, 64'hAA00000000000000, 40'h100, 64'hAA23456789ABCD55};
      vecs[3] = '{40'h100,  8'h3C, 64'h0000DEADBEEF0000, 40'h100, 64'hAA23DEADBEEFCD55};
      vecs[4] = '{40'h108,  8'hFF, 64'hFEDCBA9876543210, 40'h108, 64'hFEDCBA9876543210};
      vecs[5] = '{40'h2108, 8'hF0, 64'h1111111100000000, 40'h108, 64'h1111111176543210};
      vecs[6] = '{40'h100,  8'h00, 64'hFFFFFFFFFFFFFFFF, 40'h2100, 64'hAA23DEADBEEFCD55};

      rstn = 0;
      ld_index = 0; ld_tag = 0; ld_size = 0; st_index = 0; st_tag = 0; st_size = 0; st_wdata = 0;
      begin_cycle();
      begin_cycle();
      begin_cycle();
      #1;
      chk("rst_ld_gnt", ld_gnt, 0);
      chk("rst_st_gnt", st_gnt, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_nack", nack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_xcpt", {xcpt_ld, xcpt_st}, 0);
      rstn = 1;

      // Basic store then load.
      do_store(40'h40, 8'hFF, 64'h1122334455667788);
      do_load(40'h40, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("basic_lat", 64'(lat), LAT);
      chk("basic_data", d, 64'h1122334455667788);

      foreach (vecs[k]) begin
         do_store(vecs[k].st_addr, vecs[k].be, vecs[k].wdata);
         do_load(vecs[k].ld_addr, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
         chk($sformatf("vec%0d_data", k), d, vecs[k].exp);
      end

      // Kill in TAG wins over a simultaneous tag_valid.
      begin_cycle();
      set_ld_req(40'h40, L1D_SIZE_D);
      #1;
      chk("kill_tag_gnt", ld_gnt, 1);
      begin_cycle();
      set_ld_tag(40'h40);
      ld_kill = 1;
      #1;
      begin_cycle();
      #1;
      chk("kill_tag_busy", busy, 0);
      expect_no_resp("kill_tag_no_resp", 10);
      do_load(40'h40, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("after_kill_data", d, 64'h1122334455667788);

      // Kill while the latency counter runs.
      begin_cycle();
      set_ld_req(40'h40, L1D_SIZE_D);
      #1;
      begin_cycle();
      set_ld_tag(40'h40);
      #1;
      begin_cycle();
      ld_kill = 1;
      #1;
      chk("kill_pend_busy_before", busy, 1);
      expect_no_resp("kill_pend_no_resp", 10);

      // A second request in PEND is nacked and the first still completes on time.
      do_load(40'h40, L1D_SIZE_D, -1, 0, 0, 0, 1, d, lat);
      chk("nack_lat", 64'(lat), LAT);
      chk("nack_data", d, 64'h1122334455667788);

      // Store to the same word in the read cycle is bypassed into the response.
      do_load(40'h40, L1D_SIZE_D, LAT - 1, 40'h40, 8'h0F, 64'hAAAAAAAABBBBBBBB, -1, d, lat);
      chk("bypass_lat", 64'(lat), LAT);
      chk("bypass_data", d, 64'h11223344BBBBBBBB);

      // Store in the response cycle lands after the read.
      do_load(40'h40, L1D_SIZE_D, LAT, 40'h40, 8'hF0, 64'hCCCCCCCC00000000, -1, d, lat);
      chk("late_store_data", d, 64'h11223344BBBBBBBB);
      do_load(40'h40, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("late_store_mem", d, 64'hCCCCCCCCBBBBBBBB);

      // Misaligned accesses.
      do_store(40'h300, 8'hFF, 64'h0);
`ifdef LAGARTO_L1D_MISALIGN_CHK_EN
      begin_cycle();
      set_ld_req(40'h42, L1D_SIZE_W);
      #1;
      chk("mis_ld_xcpt", xcpt_ld, 1);
      chk("mis_ld_gnt", ld_gnt, 0);
      begin_cycle();
      #1;
      chk("mis_ld_busy", busy, 0);
      chk("mis_ld_xcpt_pulse", xcpt_ld, 0);
      begin_cycle();
      set_st(40'h301, 8'h02, 64'hFF00, L1D_SIZE_H);
      #1;
      chk("mis_st_xcpt", xcpt_st, 1);
      chk("mis_st_gnt", st_gnt, 0);
      do_load(40'h300, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("mis_st_mem", d, 64'h0);
`else
      do_load(40'h42, L1D_SIZE_W, -1, 0, 0, 0, -1, d, lat);
      chk("mis_ld_data", d, 64'hCCCCCCCCBBBBBBBB);
      begin_cycle();
      set_st(40'h301, 8'h02, 64'hFF00, L1D_SIZE_H);
      #1;
      chk("mis_st_gnt", st_gnt, 1);
      chk("mis_st_xcpt", {xcpt_ld, xcpt_st}, 0);
      do_load(40'h300, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("mis_st_mem", d, 64'h000000000000FF00);
`endif

      // Reset while the load is pending discards it.
      begin_cycle();
      set_ld_req(40'h40, L1D_SIZE_D);
      #1;
      begin_cycle();
      set_ld_tag(40'h40);
      #1;
      begin_cycle();
      rstn = 0;
      #1;
      begin_cycle();
      rstn = 1;
      #1;
      chk("rst_pend_busy", busy, 0);
      chk("rst_pend_data", resp_data, 0);
      expect_no_resp("rst_pend_no_resp", 10);
      do_load(40'h40, L1D_SIZE_D, -1, 0, 0, 0, -1, d, lat);
      chk("after_rst_data", d, 64'hCCCCCCCCBBBBBBBB);

      // Randomized traffic against a word-array model over 16 words at 0x1000,
      // addressed through random aliases of the scratchpad.
      for (int w = 0; w < 16; w++) begin
         ref_mem[w] = {$urandom, $urandom};
         do_store(40'h1000 + 40'(w) * 8, 8'hFF, ref_mem[w]);
      end
      for (int it = 0; it < 80; it++) begin
         int          w, sw, st_off, nack_off;
         logic [39:0] a, sa;
         logic [7:0]  be;
         logic [63:0] wd;
         w  = $urandom_range(0, 15);
         a  = 40'h1000 + 40'(w) * 8 + 40'($urandom_range(0, 3)) * 40'h2000;
         be = 8'($urandom);
         wd = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 0) begin
            do_store(a, be, wd);
            ref_mem[w] = merge(ref_mem[w], wd, be);
         end else begin
            logic [63:0] exp;
            exp      = ref_mem[w];
            sw       = (w + $urandom_range(1, 15)) % 16;
            sa       = 40'h1000 + 40'(sw) * 8;
            st_off   = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, LAT);
            nack_off = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, LAT);
            do_load(a, L1D_SIZE_D, st_off, sa, be, wd, nack_off, d, lat);
            if (st_off >= 0) ref_mem[sw] = merge(ref_mem[sw], wd, be);
            chk($sformatf("rnd%0d_lat", it), 64'(lat), LAT);
            chk($sformatf("rnd%0d_data", it), d, exp);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lagarto_l1d_req_responder.md
# lagarto_l1d_req_responder

Responder end of the Lagarto split load/store L1 data-cache request ports. It accepts the two-phase load protocol (index, then tag/kill) and the single-phase store protocol, and backs both with a local 64-bit-word scratchpad. It returns data, valid, nack and misalignment flags in the format the core-side data-cache interface consumes. It serves as the cache-subsystem stand-in for tile-level bring-up and as the reference responder for core-side verification.

## Interface
- MEM_WORDS, 1024: scratchpad depth in 64-bit words, power of two.
- RESP_LAT, 1: cycles from accepted tag to `dmem_resp_valid_o`; legal range 1..4.
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset, synchronous, active-low.
- ld_mem_req_addr_index_i / st_mem_req_addr_index_i  in  DCACHE_INDEX_WIDTH  request index.
- ld_mem_req_addr_tag_i / st_mem_req_addr_tag_i  in  DCACHE_TAG_WIDTH  request tag.
- ld_mem_req_valid_i / st_mem_req_valid_i  in  1  request phase valid.
- ld_mem_req_tag_valid_i / st_mem_req_tag_valid_i  in  1  tag phase valid.
- ld_mem_req_kill_i / st_mem_req_kill_i  in  1  abort the outstanding request.
- ld_mem_req_we_i / st_mem_req_we_i  in  1  write enable; the store port requires 1.
- ld_mem_req_be_i / st_mem_req_be_i  in  8  byte enables.
- ld_mem_req_size_i / st_mem_req_size_i  in  2  size: 0=B, 1=H, 2=W, 3=D.
- st_mem_req_wdata_i  in  64  store data; ld_mem_req_wdata_i is ignored.
- ld_gnt_o / st_gnt_o  out  1  request accepted this cycle.
- dmem_resp_data_o  out  64  aligned doubleword, unshifted.
- dmem_resp_valid_o  out  1  one-cycle load response pulse.
- dmem_resp_nack_o  out  1  load request refused this cycle.
- dmem_xcpt_ma_ld_o / dmem_xcpt_ma_st_o  out  1  misaligned access pulse.
- busy_o  out  1  load FSM not in IDLE.

## Operation
- Full address = {tag, index}. Word address = addr[3 +: $clog2(MEM_WORDS)]. Upper bits are ignored and the address wraps.
- Load FSM states: IDLE, TAG, PEND, RESP.
  - IDLE: if ld_valid & ~ld_kill, assert ld_gnt_o combinationally, latch index/size, go to TAG.
  - TAG: if ld_kill, go to IDLE with no response. Else if tag_valid, latch tag, load counter = RESP_LAT-1, go to PEND (or RESP when RESP_LAT=1). Else hold, with no timeout.
  - PEND: decrement the counter. ld_kill returns to IDLE and suppresses the response. At counter 0, go to RESP.
  - RESP: drive resp_valid with the read data, then go to IDLE. A kill in RESP has no effect.
- ld_valid while not IDLE: dmem_resp_nack_o=1 in the same cycle, ld_gnt_o=0. The requester must retry.
- Store port is single-phase. valid & tag_valid & we & ~kill gives st_gnt_o=1 the same cycle, and bytes with be=1 are written at the clock edge. The store port never stalls and is independent of the load FSM.
- The read is performed in the cycle the load enters RESP. Write-first: a store granted in that same cycle to the same word is bypassed into the response, byte-wise under be.
- Simultaneous load accept and store grant: both are granted.

## Timing
- Reset (rstn_i=0 at an edge): FSM → IDLE, counter=0. All outputs 0: gnt, resp_valid, nack, xcpt, busy, and resp_data=0. Scratchpad contents are not reset.
- Reset mid-operation discards any outstanding load, and no response follows.
- Minimum load: grant at cycle 0, tag at cycle 1, resp_valid at cycle 1+RESP_LAT. Back-to-back grants are at least 2+RESP_LAT cycles apart.
- gnt, nack and xcpt are combinational from the inputs and state. resp_valid and resp_data are registered.

## Configuration
- LAGARTO_L1D_MISALIGN_CHK_EN defined:
  - An access is misaligned if addr[2:0] mod 2^size ≠ 0.
  - A misaligned load in IDLE gets no grant and pulses dmem_xcpt_ma_ld_o for one cycle; the FSM stays in IDLE.
  - A misaligned store gets no grant, no write, and pulses dmem_xcpt_ma_st_o.
- Undefined: xcpt outputs are tied 0. addr[2:0] is ignored for addressing, and be alone selects bytes.

## Structure
- The following go in drac_pkg: load FSM state enum `l1d_resp_state_t`, and size encodings `L1D_SIZE_B/H/W/D`. DCACHE_INDEX_WIDTH and DCACHE_TAG_WIDTH are already provided there.
- Sub-module `l1d_resp_scratchpad`: MEM_WORDS×64 array with byte-enable write port, synchronous read port and write-first bypass. The FSM, grant/nack and misalignment logic stay in the top.

## Test plan
- Store D 0x1122334455667788 at addr 0x40 (be=0xFF), then load 0x40 with RESP_LAT=1 → st_gnt=1; ld_gnt at t0, tag at t1, resp_valid at t2 with data 0x1122334455667788.
- Load issued, then ld_kill in TAG → no resp_valid within 10 cycles; a following load is granted.
- Second ld_valid while in PEND (RESP_LAT=3) → nack=1 that cycle, gnt=0; first response arrives at t4.
- Store be=0x0F data 0xAAAAAAAA_BBBBBBBB to the word being read in the RESP-entry cycle → response upper half is old, lower half is 0xBBBBBBBB.
- With LAGARTO_L1D_MISALIGN_CHK_EN, load size=W at addr 0x42 → xcpt_ma_ld pulse, no gnt, busy stays 0. Without the macro, the same load is granted.
- Reset asserted in PEND → next cycle busy=0, resp_valid never asserts for that load.
